// File: rtl/wide_sub_sequencer.sv
// wide_sub_sequencer: multi-word subtraction sequenced through one external 16-bit subtractor; WIDE_SUB_OVERFLOW_EN adds the ovf port.
module wide_sub_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [16*NUM_WORDS-1:0] a_in,
  input  logic [16*NUM_WORDS-1:0] b_in,
  input  logic                    bin_in,
  output logic [15:0]             sub_a,
  output logic [15:0]             sub_b,
  output logic                    sub_bin,
  input  logic [15:0]             sub_Diff,
  input  logic                    sub_Bout,
`ifdef WIDE_SUB_OVERFLOW_EN
  output logic                    ovf,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [16*NUM_WORDS-1:0] diff_out,
  output logic                    bout_out
);
  localparam int W = 16*NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS-1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_borrow;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          w_run;
  // subtractor operands come from the current word while running, zero otherwise
  always_comb begin
    w_run = r_state == RUN;
    busy = w_run;
    done = r_state == DONE;
    sub_a = w_run ? r_a[16*r_idx +: 16] : '0;
    sub_b = w_run ? r_b[16*r_idx +: 16] : '0;
    sub_bin = w_run ? r_borrow : 1'b0;
  end
  // sequencing: latch operands on start, capture one result word per cycle, finish on the last word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_borrow <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      diff_out <= '0;
      bout_out <= 1'b0;
`ifdef WIDE_SUB_OVERFLOW_EN
      ovf <= 1'b0;
`endif
    end else if (!w_run) begin
      if (start) begin
        r_a <= a_in;
        r_b <= b_in;
        r_borrow <= bin_in;
        r_idx <= '0;
        r_state <= RUN;
      end else begin
        r_state <= IDLE;
      end
    end else begin
      diff_out[16*r_idx +: 16] <= sub_Diff;
      r_borrow <= sub_Bout;
      r_idx <= r_idx + 1'b1;
      if (r_idx == LAST) begin
        bout_out <= sub_Bout;
        r_state <= DONE;
`ifdef WIDE_SUB_OVERFLOW_EN
        ovf <= (r_a[W-1] ^ r_b[W-1]) & (sub_Diff[15] ^ r_a[W-1]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_wide_sub_sequencer.sv
// tb_wide_sub_sequencer: scoreboard bench for wide_sub_sequencer with a behavioural 16-bit subtractor attached.
module tb_wide_sub_sequencer;
  localparam int NW = 4;
  typedef struct {
    logic [63:0] d;
    logic        b;
    logic        o;
  } exp_t;
  logic clk = 0, reset = 1, start = 0, bin_in = 0;
  logic [63:0] a_in = '0, b_in = '0;
  logic [15:0] sub_a, sub_b, sub_Diff;
  logic sub_bin, sub_Bout, busy, done, bout_out;
  logic [63:0] diff_out;
  logic [16:0] sub_r;
`ifdef WIDE_SUB_OVERFLOW_EN
  logic ovf;
`endif
  exp_t q[$];
  int total = 0, bad = 0, n_done = 0;
  wide_sub_sequencer #(.NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .bin_in(bin_in),
    .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin), .sub_Diff(sub_Diff), .sub_Bout(sub_Bout),
`ifdef WIDE_SUB_OVERFLOW_EN
    .ovf(ovf),
`endif
    .busy(busy), .done(done), .diff_out(diff_out), .bout_out(bout_out)
  );
  assign sub_r = {1'b0, sub_a} - {1'b0, sub_b} - 17'(sub_bin);
  assign sub_Diff = sub_r[15:0];
  assign sub_Bout = sub_r[16];
  always #5 clk = ~clk;
  always @(posedge clk) if (done) n_done++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi, input bit glitch);
    logic [64:0] f;
    exp_t e;
    int lat, nd;
    f = {1'b0, a} - {1'b0, b} - 65'(bi);
    e.d = f[63:0];
    e.b = f[64];
    e.o = (a[63] ^ b[63]) & (f[63] ^ a[63]);
    q.push_back(e);
    @(negedge clk);
    start = 1; a_in = a; b_in = b; bin_in = bi;
    nd = n_done;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_run", 64'(busy), 64'd1);
      if (done) begin lat = i; break; end
      start = glitch && i <= 2;
      a_in = {$urandom(), $urandom()};
      b_in = {$urandom(), $urandom()};
      bin_in = 1'($urandom_range(0, 1));
    end
    start = 0;
    check("latency", 64'(lat), 64'(NW + 1));
    e = q.pop_front();
    check("diff", diff_out, e.d);
    check("bout", 64'(bout_out), 64'(e.b));
`ifdef WIDE_SUB_OVERFLOW_EN
    check("ovf", 64'(ovf), 64'(e.o));
`endif
    check("busy_done", 64'(busy), 64'd0);
    check("sub_a_idle", 64'(sub_a), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("diff_hold", diff_out, e.d);
    repeat (3) @(negedge clk);
    check("n_done", 64'(n_done - nd), 64'd1);
  endtask
  task automatic abort_run();
    int nd;
    @(negedge clk);
    start = 1; a_in = 64'h1234_5678_9abc_def0; b_in = 64'h1; bin_in = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("rst_diff", diff_out, 64'd0);
    check("rst_bout", 64'(bout_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sub", {47'd0, sub_bin, sub_a}, 64'd0);
`ifdef WIDE_SUB_OVERFLOW_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    reset = 0;
    nd = n_done;
    repeat (8) @(negedge clk);
    check("abort_no_done", 64'(n_done - nd), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("init_diff", diff_out, 64'd0);
    check("init_bout", 64'(bout_out), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_done", 64'(done), 64'd0);
    reset = 0;
    run_op(64'h0000_0001_0000_0000, 64'h1, 1'b0, 0);
    run_op(64'h0, 64'h1, 1'b0, 0);
    run_op(64'h5, 64'h5, 1'b1, 0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 0);
    run_op(64'h0123_4567_89ab_cdef, 64'h0011_2233_4455_6677, 1'b1, 1);
    abort_run();
    run_op(64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_fffe, 1'b1, 0);
    for (int i = 0; i < 5; i++)
      run_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), i[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wide_sub_sequencer.md
WIDE_SUB_SEQUENCER -- requirements
Module: wide_sub_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4, giving the number of 16-bit words per operand; legal range 2..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a wide subtraction.
REQ-005 SHALL have ports a_in and b_in, input, 16*NUM_WORDS, minuend and subtrahend.
REQ-006 SHALL have port bin_in, input, 1, borrow-in for the least significant word.
REQ-007 SHALL have ports sub_a and sub_b, output, 16, and sub_bin, output, 1, driving the external 16-bit subtractor's a, b and bin.
REQ-008 SHALL have ports sub_Diff, input, 16, and sub_Bout, input, 1, taken combinationally from that subtractor's Diff and Bout.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when a result becomes valid.
REQ-011 SHALL have ports diff_out, output, 16*NUM_WORDS, and bout_out, output, 1, holding the result and final borrow.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch a_in, b_in and bin_in, clear the word index to 0, set the borrow register to bin_in, and enter RUN.
REQ-014 In RUN, the block SHALL drive sub_a=a_reg[16*idx+:16], sub_b=b_reg[16*idx+:16] and sub_bin=borrow register.
REQ-015 In RUN, each edge SHALL write sub_Diff into diff_out word idx, load sub_Bout into the borrow register, and increment idx.
REQ-016 On the edge that captures word NUM_WORDS-1, the block SHALL load bout_out with sub_Bout and enter DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless start=1 (see REQ-013).
REQ-018 Latency SHALL be fixed: with start sampled at edge k, done SHALL be high in the cycle following edge k+NUM_WORDS.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in RUN, and the in-flight operation SHALL proceed unchanged.
REQ-021 Input changes on a_in, b_in and bin_in after the start edge SHALL NOT affect the in-flight operation.
REQ-022 Outside RUN, sub_a, sub_b and sub_bin SHALL be 0.
REQ-023 diff_out and bout_out SHALL hold their last value until the next completion; partial words are visible during RUN.
REQ-024 The result SHALL equal (a - b - bin) mod 2^(16*NUM_WORDS), with bout_out=1 if and only if a < b + bin, unsigned.

Reset
REQ-025 Asserting reset SHALL immediately force the following, regardless of state, including during RUN:
- state=IDLE
- idx=0
- borrow register=0
- busy=0
- done=0
- diff_out=0
- bout_out=0
- all latched operands=0
REQ-026 A run aborted by reset SHALL produce no done pulse.

Configuration
REQ-027 With macro WIDE_SUB_OVERFLOW_EN defined, the block SHALL add port ovf, output, 1, which is:
- loaded on the final-word edge with (a_msb XOR b_msb) AND (diff_msb XOR a_msb), the signed overflow of the full-width result;
- reset to 0;
- held like bout_out.
REQ-028 Without WIDE_SUB_OVERFLOW_EN, port ovf and its logic SHALL NOT exist, and all other behaviour SHALL be identical.

Verification (NUM_WORDS=4, real 16-bit subtractor attached)
REQ-029 a=0x0000000100000000, b=0x1, bin=0, start at edge 0 -> done high after edge 4; diff_out=0x00000000FFFFFFFF; bout_out=0.
REQ-030 a=0x0, b=0x1, bin=0 -> diff_out=0xFFFFFFFFFFFFFFFF; bout_out=1.
REQ-031 a=b=0x5, bin=1 -> diff_out=0xFFFFFFFFFFFFFFFF; bout_out=1.
REQ-032 With the macro defined, a=0x8000000000000000, b=0x1, bin=0 -> diff_out=0x7FFFFFFFFFFFFFFF; ovf=1; bout_out=0.
REQ-033 Pulse start again at edges 1 and 2 of a run -> ignored; exactly one done pulse, with the first operands' result.
REQ-034 Assert reset during the 2nd RUN cycle -> all outputs 0 at once; no done pulse; next start completes normally.
